// File: rtl/adder_input_sequencer_if.sv
// Bundle between the rotary/switch front end, the sequencer and the add/sub datapath.
// rot_event is a level: the sequencer reacts only to its rising edge; there is no valid/ready pair.
interface adder_input_sequencer_if;
  logic       rot_event;
  logic [3:0] inp;
  logic [6:0] res;
  logic       ovf;
  logic [6:0] a;
  logic [6:0] b;
  logic       operation;
  logic [4:0] led;
  logic       busy;
  logic       done;
  logic [3:0] step;

  modport master (
    input  rot_event, inp, res, ovf,
    output a, b, operation, led, busy, done, step
  );

  modport slave (
    output rot_event, inp, res, ovf,
    input  a, b, operation, led, busy, done, step
  );
endinterface

// File: rtl/adder_input_sequencer.sv
// Steps operand/operation capture, settle wait and result display, one rotary edge per step.
// Optional edge holdoff window is built only when ROT_HOLDOFF_EN is defined.
module adder_input_sequencer #(
    parameter int SETTLE_CYCLES = 4
`ifdef ROT_HOLDOFF_EN
    , parameter int HOLDOFF_CYCLES = 1000
`endif
) (
    input logic                      clk,
    input logic                      rst,
    adder_input_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        LOAD_A_LO = 4'd0,
        LOAD_A_HI = 4'd1,
        LOAD_B_LO = 4'd2,
        LOAD_B_HI = 4'd3,
        LOAD_OP   = 4'd4,
        SETTLE    = 4'd5,
        SHOW_LO   = 4'd6,
        SHOW_HI   = 4'd7
    } state_t;

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t         state_q, state_d;
    logic           prev_q;
    logic           rise;
    logic           edge_ok;
    logic [CW-1:0]  cnt_q;
    logic           settle_last;
    logic [6:0]     a_q, b_q, res_q;
    logic           op_q, ovf_q, done_q;

    assign rise        = bus.rot_event && !prev_q;
    assign settle_last = (cnt_q == CW'(SETTLE_CYCLES - 1));

`ifdef ROT_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    logic [HW-1:0] hold_q;

    assign edge_ok = rise && (hold_q == '0);

    always_ff @(posedge clk) begin
        if (rst)
            hold_q <= '0;
        else if (edge_ok)
            hold_q <= HW'(HOLDOFF_CYCLES);
        else if (hold_q != '0)
            hold_q <= hold_q - 1'b1;
    end
`else
    assign edge_ok = rise;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= LOAD_A_LO;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_A_LO: if (edge_ok) state_d = LOAD_A_HI;
            LOAD_A_HI: if (edge_ok) state_d = LOAD_B_LO;
            LOAD_B_LO: if (edge_ok) state_d = LOAD_B_HI;
            LOAD_B_HI: if (edge_ok) state_d = LOAD_OP;
            LOAD_OP:   if (edge_ok) state_d = SETTLE;
            SETTLE:    if (settle_last) state_d = SHOW_LO;
            SHOW_LO:   if (edge_ok) state_d = SHOW_HI;
            SHOW_HI:   if (edge_ok) state_d = LOAD_A_LO;
            default:   state_d = LOAD_A_LO;
        endcase
    end

    // Datapath capture; edges arriving in SETTLE fall through every case and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            prev_q <= bus.rot_event;
            done_q <= 1'b0;
            case (state_q)
                LOAD_A_LO: if (edge_ok) a_q[3:0] <= bus.inp;
                LOAD_A_HI: if (edge_ok) a_q[6:4] <= bus.inp[2:0];
                LOAD_B_LO: if (edge_ok) b_q[3:0] <= bus.inp;
                LOAD_B_HI: if (edge_ok) b_q[6:4] <= bus.inp[2:0];
                LOAD_OP: begin
                    if (edge_ok) begin
                        op_q  <= bus.inp[0];
                        cnt_q <= '0;
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (settle_last) begin
                        res_q  <= bus.res;
                        ovf_q  <= bus.ovf;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.led  = 5'b0;
        case (state_q)
            LOAD_A_LO, LOAD_A_HI, LOAD_B_LO, LOAD_B_HI, LOAD_OP:
                bus.led = {1'b0, bus.inp};
            SETTLE:  bus.busy = 1'b1;
            SHOW_LO: bus.led  = {ovf_q, res_q[3:0]};
            SHOW_HI: bus.led  = {ovf_q, 1'b0, res_q[6:4]};
            default: ;
        endcase
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.operation = op_q;
    assign bus.done      = done_q;
    assign bus.step      = state_q;

endmodule

// File: tb/tb_adder_input_sequencer.sv
// Random and directed bench for adder_input_sequencer with an integer-arithmetic reference model.
module tb_adder_input_sequencer;
  localparam int SETTLE = 4;

  logic clk;
  logic rst;
  adder_input_sequencer_if bus();

  adder_input_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Bit-level datapath stand-in driven by the DUT operands.
  assign bus.res = bus.operation ? (bus.a - bus.b) : (bus.a + bus.b);
  assign bus.ovf = bus.operation ? ((bus.a[6] != bus.b[6]) && (bus.res[6] != bus.a[6]))
                                 : ((bus.a[6] == bus.b[6]) && (bus.res[6] != bus.a[6]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [39:0] exp_q[$];   // {done cycle[31:0], ovf, res[6:0]}

  int a_m, b_m, op_m, res_m, ovf_m, m_step;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest pending result
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("done_cycle", cyc, int'(e[39:8]));
        chk("show_lo_led", bus.led, int'(e[7]) * 16 + int'(e[6:0]) % 16);
        chk("done_step", bus.step, 6);
      end
    end
  end

  // reference model: operands as integers, result by signed arithmetic
  task automatic model_apply(input int v);
    int sa, sb, s;
    case (m_step)
      0: begin a_m = (a_m / 16) * 16 + v;      m_step = 1; end
      1: begin a_m = a_m % 16 + (v % 8) * 16;  m_step = 2; end
      2: begin b_m = (b_m / 16) * 16 + v;      m_step = 3; end
      3: begin b_m = b_m % 16 + (v % 8) * 16;  m_step = 4; end
      4: begin
        op_m = v % 2;
        sa = (a_m >= 64) ? a_m - 128 : a_m;
        sb = (b_m >= 64) ? b_m - 128 : b_m;
        s = (op_m == 1) ? sa - sb : sa + sb;
        ovf_m = (s > 63 || s < -64) ? 1 : 0;
        res_m = (s + 256) % 128;
        exp_q.push_back({32'(cyc + SETTLE), 1'(ovf_m), 7'(res_m)});
        m_step = 5;
      end
      6: m_step = 7;
      7: m_step = 0;
      default: ;
    endcase
  endtask

  task automatic check_regs();
    chk("step", bus.step, m_step);
    chk("a", bus.a, a_m);
    chk("b", bus.b, b_m);
    if (m_step == 5) begin
      chk("busy", bus.busy, 1);
    end else if (m_step == 7) begin
      chk("show_hi_led", bus.led, ovf_m * 16 + res_m / 16);
    end else begin
      chk("op", bus.operation, op_m);
      chk("echo_led", bus.led, int'(bus.inp));
    end
  endtask

  // driver tasks
  task automatic pulse(input logic [3:0] v);
    @(negedge clk);
    bus.inp = v;
    bus.rot_event = 1'b1;
    @(negedge clk);
    bus.rot_event = 1'b0;
    model_apply(int'(v));
    check_regs();
  endtask

  task automatic settle(input bit extra);
    for (int i = 0; i < SETTLE; i++) begin
      @(negedge clk);
      if (extra && i < SETTLE - 1) bus.rot_event = (i % 2 == 0);
    end
    bus.rot_event = 1'b0;
    m_step = 6;
    chk("settle_step", bus.step, 6);
    chk("settle_busy", bus.busy, 0);
  endtask

  task automatic round(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                       input logic [3:0] v3, input logic [3:0] v4, input bit extra);
    pulse(v0); pulse(v1); pulse(v2); pulse(v3); pulse(v4);
    settle(extra);
    pulse(4'h0);
    pulse($urandom_range(0, 15));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    a_m = 0; b_m = 0; op_m = 0; m_step = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.rot_event = 1'b0;
    bus.inp = 4'h0;
    do_reset();
    repeat (3) @(negedge clk);
    chk("rst_a", bus.a, 0);
    chk("rst_b", bus.b, 0);
    chk("rst_op", bus.operation, 0);
    chk("rst_led", bus.led, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_step", bus.step, 0);
    rst = 1'b0;

    // add, overflow, subtract (with settle-time edges and a masked high bit)
    round(4'h9, 4'h1, 4'hA, 4'h0, 4'h0, 1'b0);
    round(4'hF, 4'h3, 4'h1, 4'h0, 4'h0, 1'b1);
    round(4'h5, 4'h8, 4'h7, 4'h8, 4'h1, 1'b1);

    // reset in LOAD_B_HI, coincident with a rising edge, level held through release
    pulse(4'h3); pulse(4'hC); pulse(4'h6);
    @(negedge clk);
    bus.inp = 4'h0;
    bus.rot_event = 1'b1;
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_a", bus.a, 0);
    chk("midrst_b", bus.b, 0);
    chk("midrst_step", bus.step, 0);
    chk("midrst_led", bus.led, 0);
    repeat (3) @(negedge clk);
    chk("held_level_step", bus.step, 0);
    bus.rot_event = 1'b0;
    pulse(4'h2);

    // reset landing on the settle-latch cycle cancels the done pulse
    pulse(4'h1); pulse(4'h4); pulse(4'h0); pulse(4'h1);
    repeat (SETTLE - 1) @(negedge clk);
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("settle_rst_step", bus.step, 0);
    chk("settle_rst_done", bus.done, 0);
    repeat (3) @(negedge clk);

    for (int r = 0; r < 25; r++) begin
      round($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end

    repeat (SETTLE + 2) @(negedge clk);
    chk("pending_results", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
